mem_access_unit: RTL and testbench



---
 rtl/mem_access_unit.sv | 162 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store sequencer for a big-endian word memory; sub-word stores are read-modify-write.
// Latency accept->resp: load 2, word store 2, sub-word store 3, error 1 cycles.
// One request in flight: req_ready only in IDLE. Optional MAU_ALIGN_CHECK_EN flags misaligned half/word.
module mem_access_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic                  resp_err,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    inout  wire  [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_wrt,
    output logic                  mem_en
);

    typedef enum logic [2:0] {IDLE, RD, WR, RESP, ERR} state_t;

    state_t                state;
    logic [1:0]            off_q;
    logic [1:0]            size_q;
    logic                  write_q;
    logic                  uns_q;
    logic [DATA_WIDTH-1:0] wbuf;
    logic                  req_err;

    // A misaligned half falls back to addr[1]; a word ignores the offset.
    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [1:0] off, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        h = off[1] ? w[15:0] : w[31:16];
        case (sz)
            2'b00:   extract = uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   extract = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: extract = w;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                          input logic [1:0] sz, input logic [1:0] off);
        merge = w;
        case (sz)
            2'b00: begin
                case (off)
                    2'd0:    merge[31:24] = d[7:0];
                    2'd1:    merge[23:16] = d[7:0];
                    2'd2:    merge[15:8]  = d[7:0];
                    default: merge[7:0]   = d[7:0];
                endcase
            end
            2'b01: begin
                if (off[1]) merge[15:0]  = d[15:0];
                else        merge[31:16] = d[15:0];
            end
            default: merge = d;
        endcase
    endfunction

`ifdef MAU_ALIGN_CHECK_EN
    assign req_err = (req_size == 2'b11) ||
                     (req_size == 2'b01 && req_addr[0]) ||
                     (req_size == 2'b10 && req_addr[1:0] != 2'b00);
`else
    assign req_err = (req_size == 2'b11);
`endif

    assign mem_data = (state == WR) ? wbuf : {DATA_WIDTH{1'bz}};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_addr   <= '0;
            mem_wrt    <= 1'b0;
            mem_en     <= 1'b0;
            off_q      <= 2'b00;
            size_q     <= 2'b00;
            write_q    <= 1'b0;
            uns_q      <= 1'b0;
            wbuf       <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        off_q     <= req_addr[1:0];
                        size_q    <= req_size;
                        write_q   <= req_write;
                        uns_q     <= req_unsigned;
                        wbuf      <= req_wdata;
                        mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        req_ready <= 1'b0;
                        if (req_err) begin
                            state      <= ERR;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else if (req_write && req_size == 2'b10) begin
                            state   <= WR;
                            mem_en  <= 1'b1;
                            mem_wrt <= 1'b1;
                        end else begin
                            state   <= RD;
                            mem_en  <= 1'b1;
                            mem_wrt <= 1'b0;
                        end
                    end
                end
                RD: begin
                    if (write_q) begin
                        wbuf    <= merge(mem_data, wbuf, size_q, off_q);
                        mem_wrt <= 1'b1;
                        state   <= WR;
                    end else begin
                        resp_rdata <= extract(mem_data, size_q, off_q, uns_q);
                        resp_valid <= 1'b1;
                        mem_en     <= 1'b0;
                        state      <= RESP;
                    end
                end
                WR: begin
                    mem_en     <= 1'b0;
                    mem_wrt    <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_rdata <= '0;
                    state      <= RESP;
                end
                RESP, ERR: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    mem_en    <= 1'b0;
                    mem_wrt   <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural big-endian word memory.
// Table of requests plus a hand-written reset-during-write sequence.
module tb_mem_access_unit;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr;
    wire  [31:0] mem_data;
    logic        mem_wrt;
    logic        mem_en;

    logic [31:0] mem [0:63];

    int checks = 0;
    int errors = 0;

    mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
        .resp_rdata(resp_rdata), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_wrt(mem_wrt), .mem_en(mem_en)
    );

    always #5 clock = ~clock;

    assign mem_data = (mem_en && !mem_wrt) ? mem[mem_addr[7:2]] : 32'bz;

    always @(posedge clock) begin
        if (mem_en && mem_wrt) mem[mem_addr[7:2]] <= mem_data;
    end

    typedef struct {
        logic        write;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
        logic [31:0] exp_word;
    } vec_t;

    vec_t tbl [0:14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_req(input vec_t v, input int idx);
        int lat;
        int nrd;
        int nwr;
        @(negedge clock);
        chk($sformatf("v%0d ready", idx), {31'd0, req_ready}, 32'd1);
        req_valid    = 1'b1;
        req_write    = v.write;
        req_size     = v.size;
        req_unsigned = v.uns;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        @(posedge clock);
        #1;
        req_valid    = 1'b0;
        req_write    = ~v.write;
        req_size     = ~v.size;
        req_unsigned = ~v.uns;
        req_addr     = ~v.addr;
        req_wdata    = ~v.wdata;
        lat = 0;
        nrd = 0;
        nwr = 0;
        do begin
            @(negedge clock);
            lat++;
            if (mem_en) begin
                if (mem_wrt) nwr++;
                else         nrd++;
                chk($sformatf("v%0d maddr", idx), mem_addr, {v.addr[31:2], 2'b00});
            end
        end while (!resp_valid && lat < 10);
        chk($sformatf("v%0d latency", idx), lat, v.exp_lat);
        chk($sformatf("v%0d err", idx), {31'd0, resp_err}, {31'd0, v.exp_err});
        chk($sformatf("v%0d rdata", idx), resp_rdata, v.exp_rdata);
        chk($sformatf("v%0d rd_cycles", idx), nrd, v.exp_rd);
        chk($sformatf("v%0d wr_cycles", idx), nwr, v.exp_wr);
        chk($sformatf("v%0d mem_word", idx), mem[v.addr[7:2]], v.exp_word);
        @(negedge clock);
        chk($sformatf("v%0d pulse", idx), {31'd0, resp_valid}, 32'd0);
        chk($sformatf("v%0d rdata_hold", idx), resp_rdata, v.exp_rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        mem[4]  = 32'h11223344;
        mem[8]  = 32'h80FF7F01;
        mem[12] = 32'hAABBCCDD;
        mem[20] = 32'h01020304;

        //            wr    sz     uns   addr   wdata          rdata          err  lat rd wr word
        tbl[0]  = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'h11223344, 1'b0, 2, 1, 0, 32'h11223344};
        tbl[1]  = '{1'b0, 2'b00, 1'b0, 32'h21, 32'h0,        32'hFFFFFFFF, 1'b0, 2, 1, 0, 32'h80FF7F01};
        tbl[2]  = '{1'b0, 2'b00, 1'b1, 32'h20, 32'h0,        32'h00000080, 1'b0, 2, 1, 0, 32'h80FF7F01};
        tbl[3]  = '{1'b0, 2'b01, 1'b0, 32'h22, 32'h0,        32'h00007F01, 1'b0, 2, 1, 0, 32'h80FF7F01};
        tbl[4]  = '{1'b0, 2'b01, 1'b0, 32'h20, 32'h0,        32'hFFFF80FF, 1'b0, 2, 1, 0, 32'h80FF7F01};
        tbl[5]  = '{1'b0, 2'b00, 1'b1, 32'h21, 32'h0,        32'h000000FF, 1'b0, 2, 1, 0, 32'h80FF7F01};
        tbl[6]  = '{1'b1, 2'b00, 1'b0, 32'h32, 32'hFFFFFF5A, 32'h0,        1'b0, 3, 1, 1, 32'hAABB5ADD};
        tbl[7]  = '{1'b1, 2'b01, 1'b0, 32'h30, 32'hCAFE1234, 32'h0,        1'b0, 3, 1, 1, 32'h12345ADD};
        tbl[8]  = '{1'b1, 2'b00, 1'b0, 32'h33, 32'h00000077, 32'h0,        1'b0, 3, 1, 1, 32'h12345A77};
        tbl[9]  = '{1'b1, 2'b10, 1'b0, 32'h40, 32'hDEADBEEF, 32'h0,        1'b0, 2, 0, 1, 32'hDEADBEEF};
        tbl[10] = '{1'b0, 2'b10, 1'b0, 32'h40, 32'h0,        32'hDEADBEEF, 1'b0, 2, 1, 0, 32'hDEADBEEF};
        tbl[11] = '{1'b0, 2'b11, 1'b0, 32'h10, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h11223344};
`ifdef MAU_ALIGN_CHECK_EN
        tbl[12] = '{1'b0, 2'b01, 1'b1, 32'h41, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'hDEADBEEF};
        tbl[13] = '{1'b0, 2'b10, 1'b0, 32'h13, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h11223344};
`else
        tbl[12] = '{1'b0, 2'b01, 1'b1, 32'h41, 32'h0,        32'h0000DEAD, 1'b0, 2, 1, 0, 32'hDEADBEEF};
        tbl[13] = '{1'b0, 2'b10, 1'b0, 32'h13, 32'h0,        32'h11223344, 1'b0, 2, 1, 0, 32'h11223344};
`endif
        tbl[14] = '{1'b1, 2'b11, 1'b0, 32'h30, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h12345A77};

        #12;
        chk("rst req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst resp_rdata", resp_rdata, 32'd0);
        chk("rst mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst mem_wrt", {31'd0, mem_wrt}, 32'd0);
        chk("rst mem_addr", mem_addr, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 15; i++) run_req(tbl[i], i);

        // Reset asserted in the middle of a word-store WR cycle.
        @(negedge clock);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 2'b10;
        req_unsigned = 1'b0;
        req_addr  = 32'h50;
        req_wdata = 32'hFFFFFFFF;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        chk("mid wr mem_wrt", {31'd0, mem_wrt}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid rst mem_en", {31'd0, mem_en}, 32'd0);
        chk("mid rst mem_wrt", {31'd0, mem_wrt}, 32'd0);
        chk("mid rst req_ready", {31'd0, req_ready}, 32'd1);
        chk("mid rst resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("mid rst mem_addr", mem_addr, 32'd0);
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        chk("mid rst mem_word", mem[20], 32'h01020304);
        @(negedge clock);
        chk("post rst req_ready", {31'd0, req_ready}, 32'd1);
        chk("post rst resp_valid", {31'd0, resp_valid}, 32'd0);
        run_req('{1'b0, 2'b10, 1'b0, 32'h50, 32'h0, 32'h01020304, 1'b0, 2, 1, 0, 32'h01020304}, 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
